// File: rtl/i2s_pkg.sv
// Shared I2S constants, sample type and counter sizing helper.
// Imported by the FIR stage, the TX serialiser and the RX side.
package i2s_pkg;

  localparam int I2S_DATA_WIDTH = 24;
  localparam int I2S_SLOT_BITS  = 32;
  localparam int I2S_MCLK_DIV   = 4;

  typedef logic signed [I2S_DATA_WIDTH-1:0] sample_t;

  // Register width needed to count 0..n-1 (never narrower than one bit).
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// Sample inputs and I2S line outputs of the transmit serialiser.
// The upstream sample source uses the master modport; i2s_tx uses slave.
interface i2s_tx_if
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = I2S_DATA_WIDTH
);

  logic signed [DATA_WIDTH-1:0] LEFT_TX;
  logic signed [DATA_WIDTH-1:0] RIGHT_TX;
  logic                         SCLK;
  logic                         LRCK;
  logic                         SDOUT;
  logic                         LOAD;

  modport master (
    output LEFT_TX,
    output RIGHT_TX,
    input  SCLK,
    input  LRCK,
    input  SDOUT,
    input  LOAD
  );

  modport slave (
    input  LEFT_TX,
    input  RIGHT_TX,
    output SCLK,
    output LRCK,
    output SDOUT,
    output LOAD
  );

endinterface

// File: rtl/i2s_clkgen.sv
// I2S timing generator: MCLK divider, frame bit counter and registered SCLK/LRCK.
// Shared between the TX and RX ends; LRCK_INV flips word-select polarity.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int MCLK_DIV  = I2S_MCLK_DIV,
  parameter int SLOT_BITS = I2S_SLOT_BITS,
  parameter bit LRCK_INV  = 1'b0,
  localparam int DIV_W    = cnt_width(MCLK_DIV),
  localparam int BIT_W    = cnt_width(2 * SLOT_BITS)
) (
  input  logic             MCLK,
  input  logic             RESET_N,
  output logic             sclk,
  output logic             lrck,
  output logic             tick,
  output logic             frame_end,
  output logic [BIT_W-1:0] bitcnt
);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(MCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(MCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_EDGE = BIT_W'(SLOT_BITS);

  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_next_s;
  logic [BIT_W-1:0] bit_r;
  logic [BIT_W-1:0] bit_next_s;
  logic             sclk_r;
  logic             lrck_r;
  logic             tick_r;
  logic             frame_end_r;

  // Counter step; tick_r/frame_end_r mirror the current div_r/bit_r values.
  always_comb begin
    div_next_s = div_r;
    bit_next_s = bit_r;
    if (tick_r) begin
      div_next_s = {DIV_W{1'b0}};
      if (frame_end_r) begin
        bit_next_s = {BIT_W{1'b0}};
      end else begin
        bit_next_s = bit_r + BIT_W'(1);
      end
    end else begin
      div_next_s = div_r + DIV_W'(1);
      bit_next_s = bit_r;
    end
  end

  // Counters and line outputs, all decoded from the next counter values.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      div_r       <= {DIV_W{1'b0}};
      bit_r       <= {BIT_W{1'b0}};
      sclk_r      <= 1'b0;
      lrck_r      <= 1'b0;
      tick_r      <= 1'b0;
      frame_end_r <= 1'b0;
    end else begin
      div_r       <= div_next_s;
      bit_r       <= bit_next_s;
      sclk_r      <= (div_next_s >= DIV_HALF);
      lrck_r      <= (bit_next_s >= SLOT_EDGE) ^ LRCK_INV;
      tick_r      <= (div_next_s == DIV_LAST);
      frame_end_r <= (div_next_s == DIV_LAST) && (bit_next_s == BIT_LAST);
    end
  end

  assign sclk      = sclk_r;
  assign lrck      = lrck_r;
  assign tick      = tick_r;
  assign frame_end = frame_end_r;
  assign bitcnt    = bit_r;

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: captures both channels once per frame and shifts them out MSB first.
// Build option I2S_TX_LJ_EN selects left-justified format (no bit delay, LRCK high = left).
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int MCLK_DIV   = I2S_MCLK_DIV,
  parameter int SLOT_BITS  = I2S_SLOT_BITS,
  parameter int DATA_WIDTH = I2S_DATA_WIDTH,
  localparam int BIT_W     = cnt_width(2 * SLOT_BITS),
  localparam int IDX_W     = cnt_width(DATA_WIDTH)
) (
  input  logic    MCLK,
  input  logic    RESET_N,
  i2s_tx_if.slave bus
);

`ifdef I2S_TX_LJ_EN
  localparam bit LRCK_INV_CFG = 1'b1;
`else
  localparam bit LRCK_INV_CFG = 1'b0;
`endif

  localparam logic [BIT_W-1:0] SLOT_EDGE = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] DATA_END  = BIT_W'(DATA_WIDTH);

  logic                         sclk_s;
  logic                         lrck_s;
  logic                         tick_s;
  logic                         frame_end_s;
  logic [BIT_W-1:0]             bitcnt_s;
  logic [BIT_W-1:0]             bit_next_s;
  logic [BIT_W-1:0]             pos_s;
  logic [IDX_W-1:0]             idx_s;
  logic signed [DATA_WIDTH-1:0] hold_left_r;
  logic signed [DATA_WIDTH-1:0] hold_right_r;
  logic signed [DATA_WIDTH-1:0] hold_left_next_s;
  logic signed [DATA_WIDTH-1:0] hold_right_next_s;
  logic signed [DATA_WIDTH-1:0] word_s;
  logic                         sdout_next_s;
  logic                         sdout_r;
  logic                         load_r;

  i2s_clkgen #(
    .MCLK_DIV  (MCLK_DIV),
    .SLOT_BITS (SLOT_BITS),
    .LRCK_INV  (LRCK_INV_CFG)
  ) u_clkgen (
    .MCLK      (MCLK),
    .RESET_N   (RESET_N),
    .sclk      (sclk_s),
    .lrck      (lrck_s),
    .tick      (tick_s),
    .frame_end (frame_end_s),
    .bitcnt    (bitcnt_s)
  );

  // Bit counter value after this edge, so SDOUT lands together with SCLK/LRCK.
  always_comb begin
    bit_next_s = bitcnt_s;
    if (tick_s) begin
      if (frame_end_s) begin
        bit_next_s = {BIT_W{1'b0}};
      end else begin
        bit_next_s = bitcnt_s + BIT_W'(1);
      end
    end else begin
      bit_next_s = bitcnt_s;
    end
  end

  // Both channels are taken on the same edge; inputs are ignored otherwise.
  always_comb begin
    hold_left_next_s  = hold_left_r;
    hold_right_next_s = hold_right_r;
    if (frame_end_s) begin
      hold_left_next_s  = bus.LEFT_TX;
      hold_right_next_s = bus.RIGHT_TX;
    end else begin
      hold_left_next_s  = hold_left_r;
      hold_right_next_s = hold_right_r;
    end
  end

  // Slot position, channel select and bit pick with zero padding.
  always_comb begin
    pos_s        = bit_next_s;
    word_s       = hold_left_next_s;
    idx_s        = {IDX_W{1'b0}};
    sdout_next_s = 1'b0;
    if (bit_next_s >= SLOT_EDGE) begin
      pos_s  = bit_next_s - SLOT_EDGE;
      word_s = hold_right_next_s;
    end else begin
      pos_s  = bit_next_s;
      word_s = hold_left_next_s;
    end
`ifdef I2S_TX_LJ_EN
    if (pos_s < DATA_END) begin
      idx_s        = IDX_W'(DATA_WIDTH - 1 - int'(pos_s));
      sdout_next_s = word_s[idx_s];
    end else begin
      sdout_next_s = 1'b0;
    end
`else
    if ((pos_s != {BIT_W{1'b0}}) && (pos_s <= DATA_END)) begin
      idx_s        = IDX_W'(DATA_WIDTH - int'(pos_s));
      sdout_next_s = word_s[idx_s];
    end else begin
      sdout_next_s = 1'b0;
    end
`endif
  end

  // Holding registers, serial data and the post-capture LOAD strobe.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hold_left_r  <= {DATA_WIDTH{1'b0}};
      hold_right_r <= {DATA_WIDTH{1'b0}};
      sdout_r      <= 1'b0;
      load_r       <= 1'b0;
    end else begin
      hold_left_r  <= hold_left_next_s;
      hold_right_r <= hold_right_next_s;
      sdout_r      <= sdout_next_s;
      load_r       <= frame_end_s;
    end
  end

  assign bus.SCLK  = sclk_s;
  assign bus.LRCK  = lrck_s;
  assign bus.SDOUT = sdout_r;
  assign bus.LOAD  = load_r;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: cycle timing model, edge checker and
// a scoreboard that decodes SDOUT back into samples (I2S or I2S_TX_LJ_EN build).
module tb_i2s_tx;
  import i2s_pkg::*;

  localparam int DW    = 24;
  localparam int SLOT  = 32;
  localparam int DIV   = 4;
  localparam int FRAME = 2 * SLOT * DIV;
  localparam int DRIVE_OFS = 40;   // bitcnt 10, div 0
`ifdef I2S_TX_LJ_EN
  localparam bit LJ = 1'b1;
`else
  localparam bit LJ = 1'b0;
`endif

  logic MCLK    = 1'b0;
  logic RESET_N = 1'b1;

  i2s_tx_if #(.DATA_WIDTH(DW)) bus ();

  i2s_tx dut (
    .MCLK    (MCLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 MCLK = ~MCLK;

  typedef struct {
    logic [DW-1:0] left;
    logic [DW-1:0] right;
    logic [DW-1:0] exp_left;
    logic [DW-1:0] exp_right;
  } vec_t;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } exp_t;

  vec_t vecs[9];
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit            prev_sclk    = 1'b0;
  bit            prev_lrck    = 1'b0;
  bit            prev_sdout   = 1'b0;
  bit            prev_lr_rise = 1'b0;
  bit            dec_first    = 1'b1;
  bit            dec_en       = 1'b1;
  int            pos          = 0;
  int            dpos         = 0;
  logic [DW-1:0] word         = '0;
  logic          pad          = 1'b0;
  logic          exp_sclk, exp_lrck, exp_load, is_left;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // MCLK edges since reset release.
  always @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Per-cycle timing model, edge-placement checker and SDOUT decoder.
  always @(negedge MCLK) begin
    if (!RESET_N) begin
      check("reset_outputs", {28'd0, bus.SCLK, bus.LRCK, bus.SDOUT, bus.LOAD}, 32'd0);
      dec_first = 1'b1;
      pos       = 0;
      word      = '0;
      pad       = 1'b0;
    end else begin
      exp_sclk = ((cyc % DIV) >= DIV / 2);
      exp_lrck = (cyc == 0) ? 1'b0 : (((((cyc / DIV) % (2 * SLOT)) >= SLOT) ? 1'b1 : 1'b0) ^ LJ);
      exp_load = (cyc != 0) && ((cyc % FRAME) == 0);
      check("timing_sclk_lrck_load", {29'd0, bus.SCLK, bus.LRCK, bus.LOAD},
            {29'd0, exp_sclk, exp_lrck, exp_load});
      if (cyc > 1 && (bus.LRCK !== prev_lrck || bus.SDOUT !== prev_sdout))
        check("change_only_on_sclk_fall", {30'd0, prev_sclk, bus.SCLK}, 32'd2);
      if (!prev_sclk && bus.SCLK) begin
        if (dec_first || bus.LRCK !== prev_lr_rise) pos = 0;
        else                                        pos = pos + 1;
        dec_first    = 1'b0;
        prev_lr_rise = bus.LRCK;
        if (pos == 0) begin
          word = '0;
          pad  = 1'b0;
        end
        dpos = LJ ? pos : pos - 1;
        if (dpos >= 0 && dpos < DW) word[DW-1-dpos] = bus.SDOUT;
        else                        pad = pad | bus.SDOUT;
        if (pos == SLOT - 1 && dec_en) begin
          is_left = (bus.LRCK == LJ);
          check("slot_zero_padding", {31'd0, pad}, 32'd0);
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow: got a slot with no queued sample (t=%0t)", $time);
          end else if (is_left) begin
            check("left_word", {8'd0, word}, {8'd0, sb_q[0].l});
          end else begin
            check("right_word", {8'd0, word}, {8'd0, sb_q[0].r});
            void'(sb_q.pop_front());
          end
        end
      end
    end
    prev_sclk  = bus.SCLK;
    prev_lrck  = bus.LRCK;
    prev_sdout = bus.SDOUT;
  end

  // Drive one new sample pair at bitcnt 10 of the coming frame; it goes out next frame.
  task automatic drive_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                             input logic [DW-1:0] el, input logic [DW-1:0] er);
    int n = 0;
    do begin
      @(posedge MCLK);
      #2;
      n++;
    end while ((cyc % FRAME) != DRIVE_OFS && n < 2 * FRAME);
    bus.LEFT_TX  = l;
    bus.RIGHT_TX = r;
    sb_q.push_back('{l: el, r: er});
  endtask

  task automatic wait_load(output int at_cyc);
    int n = 0;
    at_cyc = -1;
    while (n < FRAME + 64) begin
      @(posedge MCLK);
      #2;
      n++;
      if (bus.LOAD === 1'b1) begin
        at_cyc = cyc;
        break;
      end
    end
    if (at_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: got no LOAD within %0d cycles, expected one", FRAME + 64);
    end
  endtask

  int          c1, c2, n;
  logic [31:0] rl, rr;

  initial begin
    vecs[0] = '{24'h800001, 24'h7FFFFF, 24'h800001, 24'h7FFFFF};
    vecs[1] = '{24'h800001, 24'h7FFFFF, 24'h800001, 24'h7FFFFF};
    vecs[2] = '{24'hAAAAAA, 24'h123456, 24'hAAAAAA, 24'h123456};
    vecs[3] = '{24'h555555, 24'hFEDCBA, 24'h555555, 24'hFEDCBA};
    vecs[4] = '{24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF};
    vecs[5] = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000};
    vecs[6] = '{24'h000001, 24'h800000, 24'h000001, 24'h800000};
    vecs[7] = '{24'hC00003, 24'h3FFFFC, 24'hC00003, 24'h3FFFFC};
    vecs[8] = '{24'h7FFFFF, 24'h800001, 24'h7FFFFF, 24'h800001};

    bus.LEFT_TX  = '0;
    bus.RIGHT_TX = '0;
    #1 RESET_N = 1'b0;
    repeat (5) @(posedge MCLK);
    #2 RESET_N = 1'b1;
    sb_q.push_back('{l: {DW{1'b0}}, r: {DW{1'b0}}});

    for (int i = 0; i < 9; i++)
      drive_frame(vecs[i].left, vecs[i].right, vecs[i].exp_left, vecs[i].exp_right);

    fork
      begin
        wait_load(c1);
        wait_load(c2);
        if (c1 >= 0 && c2 >= 0) check("load_period", 32'(c2 - c1), 32'(FRAME));
      end
      begin
        drive_frame(24'h123ABC, 24'hABC123, 24'h123ABC, 24'hABC123);
        drive_frame(24'h0F0F0F, 24'hF0F0F0, 24'h0F0F0F, 24'hF0F0F0);
      end
    join

    for (int i = 0; i < 20; i++) begin
      rl = $urandom;
      rr = $urandom;
      drive_frame(rl[DW-1:0], rr[DW-1:0], rl[DW-1:0], rr[DW-1:0]);
    end

    // Asynchronous reset at bitcnt 40, div 2, then a cold-start replay.
    n = 0;
    do begin
      @(posedge MCLK);
      #2;
      n++;
    end while ((cyc % FRAME) != 162 && n < 2 * FRAME);
    check("pre_reset_sclk_lrck", {30'd0, bus.SCLK, bus.LRCK}, {30'd0, 1'b1, !LJ});
    RESET_N = 1'b0;
    #1;
    check("async_reset_same_cycle", {28'd0, bus.SCLK, bus.LRCK, bus.SDOUT, bus.LOAD}, 32'd0);
    repeat (3) @(posedge MCLK);
    #2;
    sb_q.delete();
    RESET_N = 1'b1;
    sb_q.push_back('{l: {DW{1'b0}}, r: {DW{1'b0}}});

    for (int i = 0; i < 4; i++)
      drive_frame(vecs[i + 2].left, vecs[i + 2].right, vecs[i + 2].exp_left, vecs[i + 2].exp_right);

    n = 0;
    while (sb_q.size() != 0 && n < 3 * FRAME) begin
      @(posedge MCLK);
      #2;
      n++;
    end
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    dec_en = 1'b0;
    repeat (8) @(posedge MCLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Serialises the filtered stereo samples (`LEFT_TX`/`RIGHT_TX`, 24-bit signed) from the FIR stage onto an I2S link toward the DAC. It is the transmit end of the audio path. It generates `SCLK` and `LRCK` from `MCLK`, captures both channels coherently once per frame, and shifts them out MSB first. A one-cycle `LOAD` strobe tells upstream logic when the samples were taken.

## Interface
- `MCLK_DIV`, 4: `MCLK` cycles per `SCLK` period. Even, ≥2.
- `SLOT_BITS`, 32: `SCLK` periods per channel slot. Must be ≥ `DATA_WIDTH`+1.
- `DATA_WIDTH`, 24: sample width.
- `MCLK` in 1: single clock for all logic.
- `RESET_N` in 1: asynchronous, active-low reset.
- `LEFT_TX` in `DATA_WIDTH`: left sample, signed. Sampled only at frame capture.
- `RIGHT_TX` in `DATA_WIDTH`: right sample, signed. Sampled only at frame capture.
- `SCLK` out 1: bit clock, `MCLK`/`MCLK_DIV`, 50% duty.
- `LRCK` out 1: word select. 0 = left slot, 1 = right slot.
- `SDOUT` out 1: serial data. Changes on the `SCLK` falling edge.
- `LOAD` out 1: one-`MCLK` pulse following each frame capture.

## Operation
- `div` counter runs 0..`MCLK_DIV`-1 and wraps.
- tick = (`div` == `MCLK_DIV`-1). At the edge ending a tick cycle, `SCLK` falls and `bitcnt` advances.
- `bitcnt` runs 0..2·`SLOT_BITS`-1 and wraps.
- Slot position p = `bitcnt` mod `SLOT_BITS`. Slot is left when `bitcnt` < `SLOT_BITS`.
- All outputs are registered and are functions of the registered counters and holding registers:
  - `SCLK` = 1 iff `div` ≥ `MCLK_DIV`/2.
  - `LRCK` = (`bitcnt` ≥ `SLOT_BITS`).
  - `SDOUT` = hold[`DATA_WIDTH`-p] for p in 1..`DATA_WIDTH`, else 0. This gives the standard I2S one-bit delay after the `LRCK` edge, with zero padding.
- Capture edge E is the `MCLK` edge where a tick coincides with `bitcnt` == 2·`SLOT_BITS`-1. At E:
  - `hold_l` ← `LEFT_TX` and `hold_r` ← `RIGHT_TX`, both at the same edge.
  - `bitcnt` ← 0.
- `LOAD` = 1 for exactly the one `MCLK` cycle after E.
- Input changes at any other time never affect the frame in flight.
- No arithmetic on samples. Bits pass through unmodified; sign is carried by the MSB.
- Reset (async assert, any time, including mid-frame):
  - `div`, `bitcnt`, `hold_l`, `hold_r` = 0.
  - `SCLK`=0, `LRCK`=0, `SDOUT`=0, `LOAD`=0.
- After `RESET_N` rises, the first frame transmits zeros. The first capture E happens 2·`SLOT_BITS`·`MCLK_DIV` `MCLK` cycles after release (256 at defaults).

## Timing
- `LOAD` period: 2·`SLOT_BITS`·`MCLK_DIV` `MCLK` cycles (256 at defaults).
- Left MSB is driven on `SDOUT` `MCLK_DIV` cycles after E. Left LSB follows at `DATA_WIDTH`·`MCLK_DIV` cycles.
- Right MSB is driven (`SLOT_BITS`+1)·`MCLK_DIV` cycles after E (132 at defaults).
- `SDOUT` and `LRCK` change only at tick edges, i.e. on the `SCLK` falling edge. They are stable across the `SCLK` rising edge.
- `LRCK` toggles every `SLOT_BITS`·`MCLK_DIV` cycles.

## Configuration
- `I2S_TX_LJ_EN` defined: left-justified format.
  - `SDOUT` = hold[`DATA_WIDTH`-1-p] for p in 0..`DATA_WIDTH`-1; no one-bit delay.
  - `LRCK` is inverted (1 = left).
  - `LOAD`, capture point and counters are unchanged.
- `I2S_TX_LJ_EN` undefined: standard I2S as described above.

## Structure
- Shared package `i2s_pkg` holds:
  - `DATA_WIDTH` and `SLOT_BITS` default localparams.
  - typedef `sample_t` (signed [`DATA_WIDTH`-1:0]).
- The FIR and the RX side import the same package.
- Sub-module `i2s_clkgen` holds the `div`/`bitcnt` counters. It outputs registered `SCLK`, `LRCK`, `tick`, `frame_end` and `bitcnt`, so the RX side can reuse it.
- The top level holds the capture registers, shift/select logic and `LOAD`.

## Test plan
- Reset hold → `SCLK`/`LRCK`/`SDOUT`/`LOAD` all 0. Release → `SCLK` period 4 `MCLK`, `LRCK` period 256 `MCLK`, first frame all-zero `SDOUT`.
- `LEFT_TX`=24'h800001, `RIGHT_TX`=24'h7FFFFF held → decoded left slot 1000…0001 at positions 1–24, positions 25–31 and 0 are 0. Right slot 0111…1111.
- Change `LEFT_TX` from 24'hAAAAAA to 24'h555555 mid-frame (bitcnt=10) → current frame still sends AAAAAA; next frame sends 555555. `LOAD` pulses exactly every 256 cycles.
- Assert `RESET_N` low at bitcnt=40, `div`=2 → all outputs 0 within the same cycle. After release, timing matches the cold start exactly.
- Checker: `SDOUT`/`LRCK` transitions only in cycles where `SCLK` goes 1→0, over 20 frames of random samples. Scoreboard reconstructs samples bit-exact.
- Build with `I2S_TX_LJ_EN`, `LEFT_TX`=24'hC00003 → MSB at position 0 while `LRCK`=1. Bits 0–23 = C00003, and the right slot appears while `LRCK`=0.
